// File: rtl/eacsu_seq_pkg.sv
// ----------------------------------------------------------------------------
// eacsu_seq_pkg
// Shared definitions for the registered Add-Compare-Select unit of the
// rate-1/2 Viterbi decoder:
//   - num_states  : trellis state count for a given constraint length
//   - init_metric : start-of-block metric for every state except state 0
//   - branch_cw   : 2-bit codeword emitted on a trellis branch
//   - sat_add     : unsigned add clamped to the metric range
// ----------------------------------------------------------------------------
package eacsu_seq_pkg;

    localparam int K_DEFAULT   = 4;
    localparam int W_DEFAULT   = 8;
    localparam int BMW_DEFAULT = 2;

    // {code bit 1, code bit 0}; numeric value selects the branch-metric field.
    typedef logic [1:0] codeword_t;

    function automatic int num_states(input int k);
        return 1 << (k - 1);
    endfunction

    // A quarter of the metric range: large enough that the all-zero start
    // state dominates for the first few steps, small enough that the
    // non-zero states cannot saturate before normalisation catches up.
    function automatic logic [31:0] init_metric(input int w);
        return 32'd1 << (w - 2);
    endfunction

    // Encoder register r = {b, p}; the new input bit sits above the K-1
    // history bits.
    function automatic codeword_t branch_cw(
        input logic [31:0] p,
        input logic        b,
        input int          k,
        input logic [31:0] g0,
        input logic [31:0] g1
    );
        logic [31:0] r;
        r = p | ({31'd0, b} << (k - 1));
        return {^(r & g0), ^(r & g1)};
    endfunction

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/acs_butterfly.sv
// ----------------------------------------------------------------------------
// acs_butterfly
// Combinational add-compare-select for one trellis state S.
//   pm_lo  : metric of the lower predecessor p0 = (2S) mod NS
//   pm_hi  : metric of the upper predecessor p1 = p0 + 1
//   bm     : branch metrics for codewords 11,10,01,00 (MSB to LSB)
//   metric : survivor metric (saturated, not yet normalised)
//   dec    : 1 when the upper predecessor survives
// Ties keep the lower predecessor.
// ----------------------------------------------------------------------------
module acs_butterfly
    import eacsu_seq_pkg::*;
#(
    parameter int             K   = 4,
    parameter logic [K-1:0]   G0  = 4'o15,
    parameter logic [K-1:0]   G1  = 4'o17,
    parameter int             W   = 8,
    parameter int             BMW = 2,
    parameter int             S   = 0
) (
    input  logic [W-1:0]       pm_lo,
    input  logic [W-1:0]       pm_hi,
    input  logic [4*BMW-1:0]   bm,
    output logic [W-1:0]       metric,
    output logic               dec
);

    localparam int   NS = num_states(K);
    localparam int   P0 = (2 * S) % NS;
    localparam int   P1 = P0 + 1;
    // Both branches into S carry the input bit that became S's MSB.
    localparam logic B  = ((S >> (K - 2)) & 1) != 0;

    codeword_t        cw_a;
    codeword_t        cw_b;
    logic [BMW-1:0]   bm_a;
    logic [BMW-1:0]   bm_b;
    logic [W-1:0]     ma;
    logic [W-1:0]     mb;

    always_comb begin
        cw_a   = branch_cw(32'(P0), B, K, 32'(G0), 32'(G1));
        cw_b   = branch_cw(32'(P1), B, K, 32'(G0), 32'(G1));
        // Codeword value doubles as the field index: 00 is the LSB field.
        bm_a   = bm[int'(cw_a) * BMW +: BMW];
        bm_b   = bm[int'(cw_b) * BMW +: BMW];
        ma     = W'(sat_add(32'(pm_lo), 32'(bm_a), W));
        mb     = W'(sat_add(32'(pm_hi), 32'(bm_b), W));
        dec    = (mb < ma);
        metric = dec ? mb : ma;
    end

endmodule

// File: rtl/eacsu_seq.sv
// ----------------------------------------------------------------------------
// eacsu_seq
// Registered Add-Compare-Select unit for a rate-1/2 Viterbi decoder with
// constraint length K (NS = 2^(K-1) states). Path metrics live here; each
// accepted trellis step adds branch metrics, selects survivors, normalises
// and reports decisions plus the best state one cycle later.
//
// Ports
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-high reset
//   start       : reload start-of-block metrics (with in_valid: the step
//                 itself is computed from the start metrics)
//   in_valid    : bm valid, one trellis step per cycle
//   bm          : branch metrics for codewords 11,10,01,00 (MSB to LSB)
//   out_valid   : dec / best_* / norm_event belong to the step just taken
//   dec         : survivor decision per state, 1 = upper predecessor
//   best_state  : lowest-index state holding the minimum metric
//   best_metric : metric of best_state
//   norm_event  : this step subtracted 2^(W-1) from all metrics
//
// dec and best_* hold between steps; norm_event is a one-cycle pulse that
// accompanies out_valid.
// ----------------------------------------------------------------------------
module eacsu_seq
    import eacsu_seq_pkg::*;
#(
    parameter int             K   = 4,
    parameter logic [K-1:0]   G0  = 4'o15,
    parameter logic [K-1:0]   G1  = 4'o17,
    parameter int             W   = 8,
    parameter int             BMW = 2,
    localparam int            NS  = num_states(K)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [4*BMW-1:0]   bm,
    output logic               out_valid,
    output logic [NS-1:0]      dec,
    output logic [K-2:0]       best_state,
    output logic [W-1:0]       best_metric,
    output logic               norm_event
);

    localparam logic [W-1:0] INIT = W'(init_metric(W));

    logic [W-1:0]   pm       [NS];
    logic [W-1:0]   pm_src   [NS];
    logic [W-1:0]   acs_m    [NS];
    logic [W-1:0]   new_m    [NS];
    logic [NS-1:0]  acs_dec;
    logic [NS-1:0]  msb;
    logic           do_norm;
    logic [K-2:0]   min_idx;
    logic [W-1:0]   min_val;

    // A step taken together with start uses the start-of-block metrics, so
    // the previous block's metrics never leak into the new block.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            if (start) begin
                pm_src[s] = (s == 0) ? '0 : INIT;
            end else begin
                pm_src[s] = pm[s];
            end
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_acs
        acs_butterfly #(
            .K   (K),
            .G0  (G0),
            .G1  (G1),
            .W   (W),
            .BMW (BMW),
            .S   (s)
        ) u_acs (
            .pm_lo  (pm_src[(2 * s) % NS]),
            .pm_hi  (pm_src[(2 * s) % NS + 1]),
            .bm     (bm),
            .metric (acs_m[s]),
            .dec    (acs_dec[s])
        );
    end

    // Normalise only when every survivor is in the upper half: clearing the
    // MSB is then an exact subtraction of 2^(W-1) that preserves all
    // metric differences.
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            msb[s] = acs_m[s][W-1];
        end
        do_norm = &msb;
        for (int s = 0; s < NS; s++) begin
            new_m[s] = acs_m[s];
            if (do_norm) begin
                new_m[s][W-1] = 1'b0;
            end
        end
    end

    // Priority scan over the normalised metrics; strict compare keeps the
    // lowest index on ties.
    always_comb begin
        min_idx = '0;
        min_val = new_m[0];
        for (int s = 1; s < NS; s++) begin
            if (new_m[s] < min_val) begin
                min_val = new_m[s];
                min_idx = (K-1)'(s);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NS; s++) begin
                pm[s] <= (s == 0) ? '0 : INIT;
            end
            out_valid   <= 1'b0;
            dec         <= '0;
            best_state  <= '0;
            best_metric <= '0;
            norm_event  <= 1'b0;
        end else begin
            out_valid  <= in_valid;
            norm_event <= in_valid && do_norm;
            if (in_valid) begin
                for (int s = 0; s < NS; s++) begin
                    pm[s] <= new_m[s];
                end
                dec         <= acs_dec;
                best_state  <= min_idx;
                best_metric <= min_val;
            end else if (start) begin
                for (int s = 0; s < NS; s++) begin
                    pm[s] <= (s == 0) ? '0 : INIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_eacsu_seq.sv
// ----------------------------------------------------------------------------
// tb_eacsu_seq
// Scoreboard bench for eacsu_seq (K=4, G0=15o, G1=17o, W=8, BMW=2).
// Stimulus pushes the hand-derived response of each step; a monitor on the
// falling edge pops and compares whenever out_valid is high.
// ----------------------------------------------------------------------------
module tb_eacsu_seq;

    typedef struct {
        int         id;
        logic [7:0] dec;
        logic [7:0] mask;
        logic [2:0] bs;
        logic [7:0] bmet;
        logic       ne;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] bm;
    logic       out_valid;
    logic [7:0] dec;
    logic [2:0] best_state;
    logic [7:0] best_metric;
    logic       norm_event;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Branch-metric vectors {11,10,01,00}
    localparam logic [7:0] BM_ZERO_RX = 8'h94;  // {2,1,1,0}
    localparam logic [7:0] BM_STATE4  = 8'h16;  // {0,1,1,2}
    localparam logic [7:0] BM_EQUAL   = 8'h55;  // {1,1,1,1}
    localparam logic [7:0] BM_ALL3    = 8'hFF;  // {3,3,3,3}

    eacsu_seq #(
        .K   (4),
        .G0  (4'o15),
        .G1  (4'o17),
        .W   (8),
        .BMW (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .bm          (bm),
        .out_valid   (out_valid),
        .dec         (dec),
        .best_state  (best_state),
        .best_metric (best_metric),
        .norm_event  (norm_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step(input logic st, input logic [7:0] b, input int id,
                        input logic [7:0] edec, input logic [7:0] emask,
                        input logic [2:0] ebs, input logic [7:0] ebm, input logic ene);
        exp_t e;
        @(posedge clk);
        #1;
        start    = st;
        in_valid = 1'b1;
        bm       = b;
        e.id = id; e.dec = edec; e.mask = emask; e.bs = ebs; e.bmet = ebm; e.ne = ene;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            start    = (i == 0) ? st : 1'b0;
            in_valid = 1'b0;
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ((((dec ^ e.dec) & e.mask) != 8'h00) || best_state !== e.bs ||
                    best_metric !== e.bmet || norm_event !== e.ne) begin
                    errors++;
                    $display("FAIL step%0d: got dec=%h best_state=%0d best_metric=%0d norm=%b expected dec=%h (mask %h) best_state=%0d best_metric=%0d norm=%b",
                             e.id, dec, best_state, best_metric, norm_event,
                             e.dec, e.mask, e.bs, e.bmet, e.ne);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        bm       = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("reset_out_valid",   32'(out_valid),   32'd0);
        chk("reset_dec",         32'(dec),         32'd0);
        chk("reset_best_state",  32'(best_state),  32'd0);
        chk("reset_best_metric", 32'(best_metric), 32'd0);
        chk("reset_norm_event",  32'(norm_event),  32'd0);

        // start alone, then five all-zero-received steps
        idle(1, 1'b1);
        step(1'b0, BM_ZERO_RX, 1, 8'h04, 8'hFF, 3'd0, 8'd0, 1'b0);
        step(1'b0, BM_ZERO_RX, 2, 8'h00, 8'hFF, 3'd0, 8'd0, 1'b0);
        for (int n = 3; n <= 5; n++)
            step(1'b0, BM_ZERO_RX, n, 8'h00, 8'h01, 3'd0, 8'd0, 1'b0);

        // start with in_valid: state 4 wins with metric 0, state 6 takes upper
        step(1'b1, BM_STATE4, 10, 8'h40, 8'hFF, 3'd4, 8'd0, 1'b0);
        idle(2, 1'b0);
        chk("hold_out_valid",   32'(out_valid),  32'd0);
        chk("hold_dec",         32'(dec),        32'h40);
        chk("hold_best_state",  32'(best_state), 32'd4);

        // equal candidates everywhere except states 0/4: lower predecessor wins
        step(1'b1, BM_EQUAL, 20, 8'h00, 8'hFF, 3'd0, 8'd1, 1'b0);

        // start without in_valid discards the metrics left by the last step
        idle(1, 1'b1);
        step(1'b0, BM_STATE4, 30, 8'h40, 8'hFF, 3'd4, 8'd0, 1'b0);

        // 200 steps of equal branch metrics; all metrics track 3n mod 128
        for (int n = 1; n <= 200; n++)
            step(n == 1, BM_ALL3, 100 + n, 8'h00, 8'hFF, 3'd0,
                 8'((3 * n) % 128), ((3 * n) % 128) < 3);

        // start with in_valid mid-stream (metrics currently all 88)
        step(1'b1, BM_STATE4, 40, 8'h40, 8'hFF, 3'd4, 8'd0, 1'b0);
        idle(2, 1'b0);

        // reset between an accepted input and its output edge
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        bm       = BM_STATE4;
        #3;
        reset = 1'b1;
        #1;
        chk("reset_inflight_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_inflight_dec",         32'(dec),         32'd0);
        chk("reset_inflight_best_metric", 32'(best_metric), 32'd0);
        // metrics are back to {0,64,...}: a plain step reproduces the fresh result
        step(1'b0, BM_STATE4, 50, 8'h40, 8'hFF, 3'd4, 8'd0, 1'b0);
        idle(5, 1'b0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
